// File: rtl/wf68k00_bus_pkg.sv
// Shared types for the 68000 bus responder: cycle FSM states, cycle classes
// and the interrupt-acknowledge function code.
package wf68k00_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM,
        ST_HOLD
    } bus_state_e;

    typedef enum logic [1:0] {
        CL_RAM,
        CL_PROT,
        CL_IACK,
        CL_UNMAPPED
    } bus_class_e;

    localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/wf68k00_bus_ram.sv
// Word-wide RAM with byte-lane synchronous writes and asynchronous read.
// Contents are deliberately not reset.
module wf68k00_bus_ram #(
  parameter int    DEPTH_LOG2 = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // be[1] is the upper lane (UDSn), be[0] the lower lane (LDSn).
  always @(posedge clk) begin
    if (we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wf68k00_bus_responder.sv
// 68000 asynchronous-bus slave: classifies each AS/DS cycle once, serves RAM,
// answers IACK with AVECn and terminates protected or unmapped cycles with BERRn.
module wf68k00_bus_responder
    import wf68k00_bus_pkg::*;
#(
    parameter int    ADDR_W      = 23,
    parameter int    DEPTH_LOG2  = 12,
    parameter int    RAM_BASE    = 0,
    parameter int    ROM_WORDS   = 4,
    parameter int    WAIT_STATES = 1,
    parameter int    BERR_CYCLES = 32,
    parameter string INIT_FILE   = ""
) (
    input  logic              CLK,
    input  logic              RESET_COREn,
    input  logic [ADDR_W-1:0] ADR,
    input  logic [2:0]        FC,
    input  logic              ASn,
    input  logic              RWn,
    input  logic              UDSn,
    input  logic              LDSn,
    input  logic [15:0]       DATA_IN,
    output logic [15:0]       DATA_OUT,
    output logic              DATA_OE,
    output logic              DTACKn,
    output logic              BERRn,
    output logic              AVECn,
    output logic [7:0]        BERR_COUNT
);

    localparam logic [ADDR_W-1:0] BASE_ADR  = ADDR_W'(RAM_BASE);
    localparam logic [7:0]        WAIT_LOAD = 8'(WAIT_STATES);
    localparam logic [7:0]        BERR_LOAD = 8'(BERR_CYCLES - 1);

    bus_state_e            state_q, state_d;
    bus_class_e            class_q, class_d, start_class;
    logic [7:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] offset_q, offset_d;
    logic                  rwn_q, rwn_d;
    logic                  dtack_n_q, dtack_n_d;
    logic                  berr_n_q, berr_n_d;
    logic                  avec_n_q, avec_n_d;
    logic                  oe_q, oe_d;
    logic [15:0]           data_q, data_d;
    logic [7:0]            berr_cnt_q, berr_cnt_d;

    logic                  start;
    logic                  in_window;
    logic                  ram_we;
    logic [1:0]            ram_be;
    logic [15:0]           ram_rdata;

    assign start     = !ASn && (!UDSn || !LDSn);
    assign in_window = (ADR >> DEPTH_LOG2) == (BASE_ADR >> DEPTH_LOG2);

    always_comb begin
        if (FC == FC_IACK) begin
            start_class = CL_IACK;
        end else if (!in_window) begin
            start_class = CL_UNMAPPED;
        end else if (!RWn && (32'(ADR[DEPTH_LOG2-1:0]) < 32'(ROM_WORDS))) begin
            start_class = CL_PROT;
        end else begin
            start_class = CL_RAM;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        rwn_d      = rwn_q;
        dtack_n_d  = dtack_n_q;
        berr_n_d   = berr_n_q;
        avec_n_d   = avec_n_q;
        oe_d       = oe_q;
        data_d     = data_q;
        berr_cnt_d = berr_cnt_q;
        ram_we     = 1'b0;
        ram_be     = {!UDSn, !LDSn};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WAIT;
                    class_d  = start_class;
                    offset_d = ADR[DEPTH_LOG2-1:0];
                    rwn_d    = RWn;
                    cnt_d    = (start_class == CL_UNMAPPED) ? BERR_LOAD : WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                // A negated AS beats the termination edge: nothing written or counted.
                if (ASn) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_TERM;
                    case (class_q)
                        CL_RAM: begin
                            dtack_n_d = 1'b0;
                            if (rwn_q) begin
                                oe_d   = 1'b1;
                                data_d = ram_rdata;
                            end else begin
                                ram_we = 1'b1;
                            end
                        end
                        CL_IACK: avec_n_d = 1'b0;
                        default: begin
                            berr_n_d = 1'b0;
                            if (berr_cnt_q != 8'hFF) berr_cnt_d = berr_cnt_q + 8'd1;
                        end
                    endcase
                end
            end
            ST_TERM: state_d = ST_HOLD;
            default: begin
                if (ASn) begin
                    state_d   = ST_IDLE;
                    dtack_n_d = 1'b1;
                    berr_n_d  = 1'b1;
                    avec_n_d  = 1'b1;
                    oe_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_COREn) begin
        if (!RESET_COREn) begin
            state_q    <= ST_IDLE;
            class_q    <= CL_RAM;
            cnt_q      <= 8'd0;
            offset_q   <= '0;
            rwn_q      <= 1'b1;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
            avec_n_q   <= 1'b1;
            oe_q       <= 1'b0;
            data_q     <= 16'h0000;
            berr_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            rwn_q      <= rwn_d;
            dtack_n_q  <= dtack_n_d;
            berr_n_q   <= berr_n_d;
            avec_n_q   <= avec_n_d;
            oe_q       <= oe_d;
            data_q     <= data_d;
            berr_cnt_q <= berr_cnt_d;
        end
    end

    wf68k00_bus_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (offset_q),
        .wdata (DATA_IN),
        .rdata (ram_rdata)
    );

    assign DATA_OUT   = data_q;
    assign DATA_OE    = oe_q;
    assign DTACKn     = dtack_n_q;
    assign BERRn      = berr_n_q;
    assign AVECn      = avec_n_q;
    assign BERR_COUNT = berr_cnt_q;

endmodule

// File: tb/tb_wf68k00_bus_responder.sv
// Bench for wf68k00_bus_responder: directed and random bus cycles against a
// word-array reference model, checked by a termination monitor.
module tb_wf68k00_bus_responder;

    localparam int ADDR_W      = 23;
    localparam int DEPTH_LOG2  = 6;
    localparam int RAM_BASE    = 0;
    localparam int ROM_WORDS   = 4;
    localparam int WAIT_STATES = 1;
    localparam int BERR_CYCLES = 32;
    localparam int WORDS       = 1 << DEPTH_LOG2;
    localparam int AMAX        = (1 << ADDR_W) - 1;

    localparam int K_RAM  = 0;
    localparam int K_PROT = 1;
    localparam int K_IACK = 2;
    localparam int K_UNM  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] adr;
    logic [2:0]        fc;
    logic              as_n, rw_n, uds_n, lds_n;
    logic [15:0]       data_in;
    logic [15:0]       data_out;
    logic              data_oe, dtack_n, berr_n, avec_n;
    logic [7:0]        berr_count;

    wf68k00_bus_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .RAM_BASE    (RAM_BASE),
        .ROM_WORDS   (ROM_WORDS),
        .WAIT_STATES (WAIT_STATES),
        .BERR_CYCLES (BERR_CYCLES),
        .INIT_FILE   ("")
    ) dut (
        .CLK         (clk),
        .RESET_COREn (rst_n),
        .ADR         (adr),
        .FC          (fc),
        .ASn         (as_n),
        .RWn         (rw_n),
        .UDSn        (uds_n),
        .LDSn        (lds_n),
        .DATA_IN     (data_in),
        .DATA_OUT    (data_out),
        .DATA_OE     (data_oe),
        .DTACKn      (dtack_n),
        .BERRn       (berr_n),
        .AVECn       (avec_n),
        .BERR_COUNT  (berr_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Expected termination: term bits are {dtack, berr, avec} asserted.
    typedef struct {
        int          start_edge;
        int          lat;
        logic [2:0]  term;
        logic        oe;
        logic [15:0] data;
        logic [7:0]  berr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [WORDS];
    int          berr_model = 0;

    function automatic int classify(input int a, input logic [2:0] f, input logic rw);
        if (f == 3'b111) return K_IACK;
        if (a < RAM_BASE || a >= RAM_BASE + WORDS) return K_UNM;
        if (!rw && (a - RAM_BASE) < ROM_WORDS) return K_PROT;
        return K_RAM;
    endfunction

    logic term_prev = 1'b0;
    always @(negedge clk) begin
        logic [2:0] tv;
        exp_t       e;
        tv = ~{dtack_n, berr_n, avec_n};
        if (rst_n && tv != 3'b000 && !term_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_term", 32'(tv), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("term_kind", 32'(tv), 32'(e.term));
                check("latency", 32'(edge_cnt - e.start_edge), 32'(e.lat));
                check("data_oe", 32'(data_oe), 32'(e.oe));
                if (e.oe) check("read_data", 32'(data_out), 32'(e.data));
                check("berr_count", 32'(berr_count), 32'(e.berr));
            end
        end
        term_prev <= (tv != 3'b000);
    end

    task automatic bus_cycle(input int a, input logic [2:0] f, input logic rw, input logic u,
                             input logic l, input logic [15:0] wd, input int late, input int abort_k);
        exp_t       e;
        int         cls;
        int         off;
        logic       seen;
        logic [2:0] tv;
        @(posedge clk); #1;
        adr     = ADDR_W'(a);
        fc      = f;
        rw_n    = rw;
        data_in = wd;
        as_n    = 1'b0;
        repeat (late) begin
            @(posedge clk); #1;
        end
        uds_n = u;
        lds_n = l;
        e.start_edge = edge_cnt + 1;
        if (abort_k > 0) begin
            repeat (abort_k) @(posedge clk);
            #1;
            as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
            repeat (3) @(negedge clk);
            check("abort_idle", 32'({dtack_n, berr_n, avec_n, data_oe}), 32'h0000000E);
            return;
        end
        cls = classify(a, f, rw);
        off = a - RAM_BASE;
        e.lat  = (cls == K_UNM) ? BERR_CYCLES : WAIT_STATES + 1;
        e.term = (cls == K_RAM) ? 3'b100 : (cls == K_IACK) ? 3'b001 : 3'b010;
        e.oe   = (cls == K_RAM) && rw;
        e.data = 16'h0000;
        if (cls == K_RAM && rw) e.data = model_mem[off];
        if (cls == K_RAM && !rw) begin
            if (!u) model_mem[off][15:8] = wd[15:8];
            if (!l) model_mem[off][7:0]  = wd[7:0];
        end
        if ((cls == K_PROT || cls == K_UNM) && berr_model < 255) berr_model++;
        e.berr = 8'(berr_model);
        exp_q.push_back(e);

        seen = 1'b0;
        for (int i = 0; i < BERR_CYCLES + 8 && !seen; i++) begin
            @(negedge clk);
            if (!dtack_n || !berr_n || !avec_n) seen = 1'b1;
        end
        check("term_seen", 32'(seen), 32'd1);
        if (!seen) void'(exp_q.pop_back());
        @(posedge clk); #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(negedge clk);
        tv = ~{dtack_n, berr_n, avec_n};
        if (seen) check("hold_term", 32'(tv), 32'(e.term));
        @(posedge clk);
        @(negedge clk);
        check("release", 32'({dtack_n, berr_n, avec_n, data_oe}), 32'h0000000E);
    endtask

    task automatic reset_mid_write(input int a, input logic [15:0] wd);
        @(posedge clk); #1;
        adr = ADDR_W'(a); fc = 3'b001; rw_n = 1'b0; data_in = wd;
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {4'h0, dtack_n, berr_n, avec_n, data_oe, data_out, berr_count},
              {4'h0, 3'b111, 1'b0, 16'h0000, 8'h00});
        berr_model = 0;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int r, a, k, ul;
        logic [2:0] f;
        logic rw;
        rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
        fc = 3'b000; adr = '0; data_in = 16'h0000;
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i] = (i == 0) ? 16'h0001 : 16'($urandom);
            dut.u_ram.mem[i] <= model_mem[i];
        end
        #12;
        check("reset_outputs",
              {4'h0, dtack_n, berr_n, avec_n, data_oe, data_out, berr_count},
              {4'h0, 3'b111, 1'b0, 16'h0000, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_cycle(RAM_BASE + 0, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(RAM_BASE + 8, 3'b001, 1'b0, 1'b1, 1'b0, 16'hA55A, 0, 0);
        bus_cycle(RAM_BASE + 8, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(RAM_BASE + 1, 3'b001, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0, 0);
        bus_cycle(RAM_BASE + 1, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(RAM_BASE + WORDS, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(12345, 3'b111, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(RAM_BASE + 20, 3'b001, 1'b0, 1'b0, 1'b1, 16'h1234, 2, 0);
        bus_cycle(RAM_BASE + 20, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);

        bus_cycle(RAM_BASE + 10, 3'b001, 1'b0, 1'b0, 1'b0, 16'hDEAD, 0, 1);
        bus_cycle(RAM_BASE + 11, 3'b001, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, WAIT_STATES + 1);
        bus_cycle(RAM_BASE + 10, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        bus_cycle(RAM_BASE + 11, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        reset_mid_write(RAM_BASE + 12, 16'hC0DE);
        bus_cycle(RAM_BASE + 12, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) a = RAM_BASE + int'($urandom_range(0, WORDS - 1));
            else a = int'($urandom_range(WORDS, AMAX));
            f  = (r >= 8) ? 3'b111 : 3'($urandom_range(1, 6));
            rw = 1'($urandom_range(0, 1));
            ul = int'($urandom_range(0, 2));
            k  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WAIT_STATES + 1)) : 0;
            bus_cycle(a, f, rw, ul == 2, ul == 1, 16'($urandom), int'($urandom_range(0, 2)), k);
        end

        for (int n = 0; n < 300 && berr_model < 255; n++) begin
            bus_cycle(RAM_BASE + WORDS + n, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);
        end
        repeat (3) bus_cycle(AMAX, 3'b110, 1'b0, 1'b0, 1'b0, 16'h5555, 0, 0);
        bus_cycle(RAM_BASE + 1, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
